// File: rtl/uart_rx_ctrl_if.sv
// Host-side bundle of the UART receiver: serial line in, receive data
// register and status flags out.
interface uart_rx_ctrl_if;
  logic       rxd;
  logic       rdrf_clr;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       fe;
  logic       oe;
  logic       busy;

  modport master (output rxd, rdrf_clr, input rx_data, rdrf, fe, oe, busy);
  modport slave  (input rxd, rdrf_clr, output rx_data, rdrf, fe, oe, busy);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver with 8x oversampling: start/data/stop framing, a single data
// register and full/framing/overrun flags.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic           bclk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, RDATA, STOP} state_t;

  state_t     state;
  logic       sync1, rxs;
  logic [2:0] sct;
  logic [3:0] bct;
  logic [7:0] rsr, rdr;
  logic       rdrf_q, fe_q, oe_q;
  logic       rdrf_k, oe_k;

  // Host acknowledge takes effect before any load on the same edge.
  assign rdrf_k = rdrf_q & ~bus.rdrf_clr;
  assign oe_k   = oe_q & ~bus.rdrf_clr;

  always_ff @(posedge bclk) begin
    if (rst) begin
      state  <= IDLE;
      sync1  <= 1'b1;
      rxs    <= 1'b1;
      sct    <= 3'd0;
      bct    <= 4'd0;
      rsr    <= 8'd0;
      rdr    <= 8'd0;
      rdrf_q <= 1'b0;
      fe_q   <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      sync1  <= bus.rxd;
      rxs    <= sync1;
      rdrf_q <= rdrf_k;
      oe_q   <= oe_k;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            sct   <= 3'd0;
          end
        end
        START: begin
          sct <= sct + 3'd1;
          if (sct == 3'd3) begin
            if (!rxs) begin
              state <= RDATA;
              sct   <= 3'd0;
              bct   <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        RDATA: begin
          sct <= sct + 3'd1;
          if (sct == 3'd7) begin
            // LSB-first: new bit enters at the top of the DATA_BITS field.
            rsr <= (rsr >> 1) | (8'(rxs) << (DATA_BITS - 1));
            bct <= bct + 4'd1;
            if (bct == 4'(DATA_BITS - 1))
              state <= STOP;
          end
        end
        STOP: begin
          sct <= sct + 3'd1;
          if (sct == 3'd7) begin
            state <= IDLE;
            if (rdrf_k) begin
              oe_q <= 1'b1;
            end else begin
              rdr    <= rsr;
              rdrf_q <= 1'b1;
              fe_q   <= ~rxs;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = rdr;
  assign bus.rdrf    = rdrf_q;
  assign bus.fe      = fe_q;
  assign bus.oe      = oe_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 Port: bclk  input  1  receive sample clock, 8x the baud rate; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: rxd  input  1  serial line, idle high, asynchronous to bclk.
REQ-005 Port: rdrf_clr  input  1  host read acknowledge, one-cycle pulse.
REQ-006 Port: rx_data  output  8  received data register (RDR), LSB-aligned, unused upper bits 0.
REQ-007 Port: rdrf  output  1  receive data register full.
REQ-008 Port: fe  output  1  framing error of the frame currently in RDR.
REQ-009 Port: oe  output  1  overrun error, sticky until rdrf_clr.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all references to rxd below mean the synchronized value (rxs).
REQ-012 The FSM SHALL have four states: IDLE, START, RDATA, STOP, with a 3-bit sample counter (sct) and 4-bit bit counter (bct).
REQ-013 IDLE: rxs=0 -> START with sct cleared; otherwise remain.
REQ-014 START: sct increments each cycle; at sct=3 (mid start bit) rxs=0 -> RDATA with sct and bct cleared; rxs=1 -> IDLE (glitch rejected, no flags change).
REQ-015 RDATA: sct increments each cycle; at sct=7 rxs SHALL be shifted into the receive shift register (RSR) LSB-first and bct incremented; sct wraps 7->0.
REQ-016 RDATA -> STOP on the sample where bct reaches DATA_BITS.
REQ-017 STOP: at sct=7 the stop bit SHALL be sampled; next cycle-edge loads RDR from RSR, sets rdrf=1, fe = NOT stop-bit sample, and returns to IDLE.
REQ-018 A new start bit SHALL be detectable in IDLE the cycle after the STOP transition (no extra idle required).
REQ-019 Overrun: if rdrf=1 at the STOP load, RDR and fe SHALL NOT be updated, oe SHALL be set to 1, rdrf stays 1.
REQ-020 rdrf_clr=1 SHALL clear rdrf and oe on the next edge; rx_data and fe hold their values.
REQ-021 Simultaneous rdrf_clr and STOP load: rdrf_clr is applied first, so the load proceeds normally (rdrf=1, oe=0, RDR updated).
REQ-022 busy SHALL be combinational from state (0 only in IDLE).
REQ-023 Frame-to-rdrf latency: rdrf SHALL rise exactly 2 (sync) + 4 + 8*DATA_BITS + 8 bclk edges after the first bclk edge that sees rxd low, +/-0 in simulation with edge-aligned stimulus.

Reset
REQ-024 rst=1 SHALL force state IDLE, sct=0, bct=0, RSR=0, synchronizer flops=1, and on outputs rx_data=0, rdrf=0, fe=0, oe=0, busy=0 at the next edge.
REQ-025 rst asserted mid-frame SHALL abort the frame with no RDR update; reception resumes with the next falling edge after rst deasserts.

Verification
REQ-026 Frame 0x5A, DATA_BITS=8, valid stop -> rx_data=0x5A, rdrf=1, fe=0, oe=0 at the latency of REQ-023.
REQ-027 rxd low for 2 bclk cycles only -> FSM returns to IDLE, rdrf=0, no flag change.
REQ-028 Frame 0xA5 with stop bit driven 0 -> rx_data=0xA5, rdrf=1, fe=1.
REQ-029 Frame 0x11 unread, then frame 0x22 -> rx_data=0x11, rdrf=1, oe=1; rdrf_clr pulse -> rdrf=0, oe=0.
REQ-030 rdrf_clr pulsed on the exact STOP load cycle of frame 0x3C -> rx_data=0x3C, rdrf=1, oe=0.
REQ-031 rst pulsed during bit 4 of frame 0xFF, then frame 0x81 -> only 0x81 captured, rdrf=1, fe=0.
